// File: rtl/alu_seq.sv
// Sequential handshaked ALU: single-cycle logic ops, iterative multiply and restoring divide.
// Optional build macro ALU_FAST_MUL_EN makes MUL/MULH single-cycle combinational multiplies.
module alu_seq #(
  parameter int SIZE = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      funct,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] result,
  output logic            overflow,
  output logic            negative,
  output logic            zero,
  output logic            div_by_zero,
  output logic            busy
);

  localparam int SW = $clog2(SIZE);

  localparam logic [3:0] F_SUM  = 4'd0,  F_SUB  = 4'd1,  F_SHL  = 4'd2,  F_SHR = 4'd3;
  localparam logic [3:0] F_LOAD = 4'd4,  F_AND  = 4'd5,  F_XOR  = 4'd6,  F_NOT = 4'd7;
  localparam logic [3:0] F_MUL  = 4'd8,  F_MULH = 4'd9,  F_DIV  = 4'd10, F_REM = 4'd11;
  localparam logic [3:0] F_DIVU = 4'd12, F_REMU = 4'd13, F_SRA  = 4'd14;

`ifdef ALU_FAST_MUL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`endif

  state_t state, state_next;

  // Shared iteration registers: multiply uses {hi,lo} as product/multiplier,
  // divide uses hi as partial remainder and lo as dividend/quotient.
  logic [3:0]      op_q;
  logic            qneg_q, aneg_q;
  logic [SIZE-1:0] hi_q, lo_q, opb_q;
  logic [SW-1:0]   cnt_q;

  logic            accept;
  logic [SW-1:0]   shamt;
  logic [SIZE-1:0] a_abs, b_abs;
  logic            div_signed;

  logic [SIZE:0]     mul_sum;
  logic [SIZE-1:0]   mul_hi_n, mul_lo_n;
  logic [2*SIZE-1:0] prod_fix;

  logic [SIZE:0]   rem_sh, rem_diff;
  logic            rem_ge;
  logic [SIZE-1:0] div_r_n, div_q_n, quo_fix, rem_fix;

  logic            load;
  logic [SIZE-1:0] fin_res;
  logic            fin_ovf, fin_dbz;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
`ifdef ALU_FAST_MUL_EN
  assign busy = (state == DIV);
`else
  assign busy = (state == MUL) || (state == DIV);
`endif

  assign accept     = in_valid && in_ready;
  assign shamt      = b[SW-1:0];
  assign a_abs      = a[SIZE-1] ? -a : a;
  assign b_abs      = b[SIZE-1] ? -b : b;
  assign div_signed = (funct == F_DIV) || (funct == F_REM);

  // One radix-2 shift-add step
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
  assign mul_hi_n = mul_sum[SIZE:1];
  assign mul_lo_n = {mul_sum[0], lo_q[SIZE-1:1]};
  assign prod_fix = qneg_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};

  // One restoring-division step
  assign rem_sh   = {hi_q, lo_q[SIZE-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};
  assign rem_ge   = !rem_diff[SIZE];
  assign div_r_n  = rem_ge ? rem_diff[SIZE-1:0] : rem_sh[SIZE-1:0];
  assign div_q_n  = {lo_q[SIZE-2:0], rem_ge};
  assign quo_fix  = qneg_q ? -div_q_n : div_q_n;
  assign rem_fix  = aneg_q ? -div_r_n : div_r_n;

`ifdef ALU_FAST_MUL_EN
  logic [2*SIZE-1:0] fast_prod;
  assign fast_prod = $signed(a) * $signed(b);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_next = state;
    load       = 1'b0;
    fin_res    = '0;
    fin_ovf    = 1'b0;
    fin_dbz    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load       = 1'b1;
          state_next = DONE;
          unique case (funct)
            F_SUM: begin
              fin_res = a + b;
              fin_ovf = (a[SIZE-1] == b[SIZE-1]) && (fin_res[SIZE-1] != a[SIZE-1]);
            end
            F_SUB: begin
              fin_res = a - b;
              fin_ovf = (a[SIZE-1] != b[SIZE-1]) && (fin_res[SIZE-1] != a[SIZE-1]);
            end
            F_SHL:  fin_res = a << shamt;
            F_SHR:  fin_res = a >> shamt;
            F_LOAD: fin_res = b;
            F_AND:  fin_res = a & b;
            F_XOR:  fin_res = a ^ b;
            F_NOT:  fin_res = ~a;
            F_SRA:  fin_res = $signed(a) >>> shamt;
            F_MUL, F_MULH: begin
`ifdef ALU_FAST_MUL_EN
              fin_res = (funct == F_MUL) ? fast_prod[SIZE-1:0] : fast_prod[2*SIZE-1:SIZE];
`else
              load       = 1'b0;
              state_next = MUL;
`endif
            end
            F_DIV, F_REM, F_DIVU, F_REMU: begin
              if (b == '0) begin
                fin_dbz = 1'b1;
                fin_res = (funct == F_DIV || funct == F_DIVU) ? '1 : a;
              end else begin
                load       = 1'b0;
                state_next = DIV;
              end
            end
            default: fin_res = '0;
          endcase
        end
      end
`ifndef ALU_FAST_MUL_EN
      MUL: begin
        if (cnt_q == '0) begin
          load       = 1'b1;
          state_next = DONE;
          fin_res    = (op_q == F_MUL) ? prod_fix[SIZE-1:0] : prod_fix[2*SIZE-1:SIZE];
        end
      end
`endif
      DIV: begin
        if (cnt_q == '0) begin
          load       = 1'b1;
          state_next = DONE;
          fin_res    = (op_q == F_DIV || op_q == F_DIVU) ? quo_fix : rem_fix;
        end
      end
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result      <= '0;
      overflow    <= 1'b0;
      negative    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      op_q        <= '0;
      qneg_q      <= 1'b0;
      aneg_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      cnt_q       <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
      if (load) begin
        result      <= fin_res;
        overflow    <= fin_ovf;
        negative    <= fin_res[SIZE-1];
        zero        <= (fin_res == '0);
        div_by_zero <= fin_dbz;
      end
      if (accept) begin
        op_q  <= funct;
        cnt_q <= SW'(SIZE - 1);
        hi_q  <= '0;
        if (funct == F_MUL || funct == F_MULH) begin
          lo_q   <= b_abs;
          opb_q  <= a_abs;
          qneg_q <= a[SIZE-1] ^ b[SIZE-1];
          aneg_q <= 1'b0;
        end else begin
          lo_q   <= div_signed ? a_abs : a;
          opb_q  <= div_signed ? b_abs : b;
          qneg_q <= div_signed && (a[SIZE-1] ^ b[SIZE-1]);
          aneg_q <= div_signed && a[SIZE-1];
        end
`ifndef ALU_FAST_MUL_EN
      end else if (state == MUL) begin
        hi_q  <= mul_hi_n;
        lo_q  <= mul_lo_n;
        cnt_q <= cnt_q - 1'b1;
`endif
      end else if (state == DIV) begin
        hi_q  <= div_r_n;
        lo_q  <= div_q_n;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Sequential, handshaked successor to the combinational datapath ALU.
- Keeps the 8 base operations.
- Adds iterative multiply (low/high) and signed/unsigned divide/remainder, plus arithmetic shift right.
- Result and status flags are registered.
- Sits in the execute stage; the stall logic uses in_ready/out_valid to freeze the pipeline during multi-cycle ops.

Parameters:
SIZE, 64, operand/result width in bits (>= 4)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
funct  input  4  operation select (encoding below)
a  input  SIZE  operand A (signed unless op says otherwise)
b  input  SIZE  operand B
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result
result  output  SIZE  registered operation result
overflow  output  1  signed overflow (SUM/SUB only, else 0)
negative  output  1  result[SIZE-1]
zero  output  1  result == 0
div_by_zero  output  1  divide/remainder op with b == 0
busy  output  1  multi-cycle op in progress

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on port reset.
- funct encoding:
  - 0 SUM, 1 SUB, 2 SHL (a << b[log2 SIZE-1:0]), 3 SHR logical, 4 LOAD (b), 5 AND, 6 XOR, 7 NOT a
  - 8 MUL (low SIZE bits), 9 MULH (signed high SIZE bits)
  - 10 DIV signed, 11 REM signed, 12 DIVU, 13 REMU, 14 SRA, 15 reserved (result 0)
- States: IDLE, MUL, DIV, DONE.
- in_ready = (state == IDLE). Request accepted when in_valid && in_ready; a, b, funct captured on that edge.
- Single-cycle ops (0-7, 14, 15): IDLE→DONE. out_valid = 1 on the cycle after acceptance (latency 1).
- MUL/MULH: IDLE→MUL, radix-2 shift-add over operand magnitudes, sign fix-up at end.
  - Exactly SIZE iteration cycles, then DONE. out_valid asserts SIZE+1 cycles after acceptance.
- DIV family: IDLE→DIV, restoring division on magnitudes, SIZE cycles, sign fix-up, then DONE.
  - Same latency as multiply.
  - Quotient sign = sign(a)^sign(b); remainder sign = sign(a).
- Divide boundaries:
  - b == 0: skip iteration, go IDLE→DONE in 1 cycle. Quotient = all ones, remainder = a, div_by_zero = 1.
  - Signed a = most-negative, b = -1: quotient = most-negative, remainder = 0, overflow = 0, normal latency.
- DONE: result and flags held stable while out_valid && !out_ready. DONE→IDLE on out_ready. No new request accepted in DONE.
- busy = 1 in MUL and DIV only.
- Flags:
  - Computed from the final result and registered together with it.
  - overflow follows two's-complement rule: SUM sets it on equal input signs with a differing result sign; SUB sets it on differing input signs with result sign ≠ a sign.
  - div_by_zero is 0 for non-divide ops.
- Shift amounts use the low log2(SIZE) bits of b; upper bits are ignored.
- Reset (also mid-operation):
  - state = IDLE; in_ready = 1 in the cycle after reset deasserts.
  - out_valid, busy, result, all flags = 0.
  - In-flight op discarded, no output produced.
- in_valid while not in_ready: ignored; the requester must hold it.

Optional Feature:
ALU_FAST_MUL_EN
- Defined: MUL/MULH use a single combinational SIZE×SIZE multiply and behave as single-cycle ops (IDLE→DONE, latency 1, busy never asserted for multiply). The MUL state is not built.
- Undefined: iterative multiply as above, SIZE+1 cycle latency.
- Divide is iterative in both builds.

Test Plan:
- SUM 0x7FFF…FF + 1, out_ready=1 → out_valid 1 cycle after accept; result 0x8000…00, overflow=1, negative=1, zero=0.
- MUL a=-3, b=7 (SIZE=8) → result 0xEB after 9 cycles; MULH same operands → 0xFF; busy high for 8 cycles.
  - With ALU_FAST_MUL_EN: both ops complete in 1 cycle.
- DIV a=-7, b=2 → result -3; REM a=-7, b=2 → -1; DIVU a=0xF9, b=2 (SIZE=8) → 0x7C.
- DIV a=5, b=0 → 1 cycle; result all ones, div_by_zero=1. REM a=5, b=0 → result 5.
- DIV a=0x80, b=0xFF (SIZE=8) → result 0x80, overflow=0. Hold out_ready=0 for 5 cycles → result stable, in_ready=0 throughout.
- Assert reset at iteration 4 of a DIV → next cycle out_valid=0, busy=0, result=0. A following SUB 5-5 → zero=1.
